// File: rtl/instr_fetch.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | instr_fetch: PC walker + optional immediate gather for the CPU core.  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module instr_fetch #(
  parameter int                 ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [5:0]         HALT_OP  = 6'b111111
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_data,
  output logic [15:0]       instr,
  output logic [5:0]        opcode,
  output logic [15:0]       imm,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc_out,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ_I  = 3'd1,
    S_CAP_I  = 3'd2,
    S_CAP_M  = 3'd3,
    S_ISSUE  = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic [15:0]       instr_q, instr_d;
  logic [15:0]       imm_q, imm_d;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    instr_d  = instr_q;
    imm_d    = imm_q;
    case (state_q)
      S_IDLE: state_d = S_REQ_I;
      S_REQ_I: begin
        pc_out_d = pc_q;
        pc_d     = pc_q + ADDR_W'(1);
        state_d  = S_CAP_I;
      end
      S_CAP_I: begin
        instr_d = mem_data;
        if (mem_data[9]) begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_CAP_M;
        end else begin
          imm_d   = 16'h0000;
          state_d = S_ISSUE;
        end
      end
      S_CAP_M: begin
        imm_d   = mem_data;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (instr_ready) begin
          state_d = (instr_q[15:10] == HALT_OP) ? S_HALTED : S_REQ_I;
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
    // A redirect overrides everything, including an accept in the same cycle.
    if (branch_en) begin
      pc_d    = branch_target;
      state_d = S_REQ_I;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      pc_out_q <= '0;
      instr_q  <= 16'h0000;
      imm_q    <= 16'h0000;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
      imm_q    <= imm_d;
    end
  end

  // The immediate read is issued from CAP_I while the opcode word arrives.
  assign mem_rd      = (state_q == S_REQ_I) || ((state_q == S_CAP_I) && mem_data[9]);
  assign mem_addr    = pc_q;
  assign instr_valid = (state_q == S_ISSUE);
  assign halted      = (state_q == S_HALTED);
  assign instr       = instr_q;
  assign opcode      = instr_q[15:10];
  assign imm         = imm_q;
  assign pc_out      = pc_out_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_instr_fetch: scoreboard bench for instr_fetch (plus wrap instance). |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_instr_fetch;

  typedef struct packed {
    logic [15:0] instr;
    logic [5:0]  op;
    logic [15:0] imm;
    logic [7:0]  pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, rst2;
  logic        mem_rd, mem_rd2;
  logic [7:0]  mem_addr, mem_addr2;
  logic [15:0] mem_data, mem_data2;
  logic [15:0] instr, instr2, imm, imm2;
  logic [5:0]  opcode, opcode2;
  logic        instr_valid, instr_valid2;
  logic        instr_ready, instr_ready2;
  logic [7:0]  pc_out, pc_out2;
  logic        branch_en, branch_en2;
  logic [7:0]  branch_target, branch_target2;
  logic        halted, halted2;

  logic [15:0] mem [0:255];
  exp_t        q1[$];
  exp_t        q2[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_pop1   = 0;
  int          n_pop2   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd)  mem_data  <= mem[mem_addr];
  always @(posedge clk) if (mem_rd2) mem_data2 <= mem[mem_addr2];

  instr_fetch #(.ADDR_W(8), .RESET_PC(8'h00), .HALT_OP(6'b111111)) u_dut (
    .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .instr(instr), .opcode(opcode), .imm(imm), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc_out(pc_out), .branch_en(branch_en),
    .branch_target(branch_target), .halted(halted)
  );

  instr_fetch #(.ADDR_W(8), .RESET_PC(8'hFF), .HALT_OP(6'b111111)) u_wrap (
    .clk(clk), .rst(rst2), .mem_rd(mem_rd2), .mem_addr(mem_addr2), .mem_data(mem_data2),
    .instr(instr2), .opcode(opcode2), .imm(imm2), .instr_valid(instr_valid2),
    .instr_ready(instr_ready2), .pc_out(pc_out2), .branch_en(branch_en2),
    .branch_target(branch_target2), .halted(halted2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp_xfer(input string tag, input exp_t e, input logic [15:0] i,
                          input logic [5:0] o, input logic [15:0] m, input logic [7:0] p);
    chk({tag, ".instr"},  {16'h0, i}, {16'h0, e.instr});
    chk({tag, ".opcode"}, {26'h0, o}, {26'h0, e.op});
    chk({tag, ".imm"},    {16'h0, m}, {16'h0, e.imm});
    chk({tag, ".pc_out"}, {24'h0, p}, {24'h0, e.pc});
  endtask

  initial begin
    rst = 1'b0; rst2 = 1'b0;
    instr_ready = 1'b1; instr_ready2 = 1'b1;
    branch_en = 1'b0; branch_en2 = 1'b0;
    branch_target = 8'h00; branch_target2 = 8'h00;
    mem_data = 16'h0; mem_data2 = 16'h0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = 16'h0100;
    mem[8'h01] = 16'h4A00; mem[8'h02] = 16'h1234;
    mem[8'h03] = 16'h0800;
    mem[8'h04] = 16'h0E00; mem[8'h05] = 16'hBEEF;
    mem[8'h40] = 16'h1000; mem[8'h41] = 16'hFC00;
    mem[8'h10] = 16'h2600; mem[8'h11] = 16'h5555;
    mem[8'hFF] = 16'h0600;

    fork
      forever begin
        @(negedge clk);
        if (rst && instr_valid && instr_ready) begin
          n_pop1++;
          if (q1.size() == 0) chk("dut_unexpected_xfer", {16'h0, instr}, 32'hFFFF_FFFF);
          else cmp_xfer("dut", q1.pop_front(), instr, opcode, imm, pc_out);
        end
        if (rst2 && instr_valid2 && instr_ready2) begin
          n_pop2++;
          if (q2.size() == 0) chk("wrap_unexpected_xfer", {16'h0, instr2}, 32'hFFFF_FFFF);
          else cmp_xfer("wrap", q2.pop_front(), instr2, opcode2, imm2, pc_out2);
        end
      end
    join_none

    repeat (3) tick();
    chk("rst.instr_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst.mem_rd",      {31'h0, mem_rd},      32'h0);
    chk("rst.mem_addr",    {24'h0, mem_addr},    32'h0);
    chk("rst.halted",      {31'h0, halted},      32'h0);
    chk("rst.instr",       {16'h0, instr},       32'h0);
    chk("rst.imm",         {16'h0, imm},         32'h0);
    chk("rst.pc_out",      {24'h0, pc_out},      32'h0);
    chk("rst2.mem_addr",   {24'h0, mem_addr2},   32'hFF);
    chk("rst2.mem_rd",     {31'h0, mem_rd2},     32'h0);

    q1.push_back('{16'h0100, 6'd0,  16'h0000, 8'h00});
    q1.push_back('{16'h4A00, 6'd18, 16'h1234, 8'h01});
    q1.push_back('{16'h0800, 6'd2,  16'h0000, 8'h03});

    rst = 1'b1;
    tick();                                       // IDLE -> REQ_I
    chk("first.mem_rd",   {31'h0, mem_rd},   32'h1);
    chk("first.mem_addr", {24'h0, mem_addr}, 32'h0);
    tick();
    chk("first.valid_early", {31'h0, instr_valid}, 32'h0);
    tick();
    chk("first.valid_at3", {31'h0, instr_valid}, 32'h1);
    tick(); tick();                               // REQ_I(1), CAP_I
    chk("imm.mem_rd",   {31'h0, mem_rd},   32'h1);
    chk("imm.mem_addr", {24'h0, mem_addr}, 32'h2);
    tick(); tick();
    chk("imm.valid", {31'h0, instr_valid}, 32'h1);
    tick();
    chk("next.mem_rd",   {31'h0, mem_rd},   32'h1);
    chk("next.mem_addr", {24'h0, mem_addr}, 32'h3);
    instr_ready = 1'b0;
    tick(); tick();                               // now held in ISSUE
    for (int i = 0; i < 5; i++) begin
      chk("bp.valid",  {31'h0, instr_valid}, 32'h1);
      chk("bp.mem_rd", {31'h0, mem_rd},      32'h0);
      chk("bp.instr",  {16'h0, instr},       32'h0800);
      chk("bp.pc_out", {24'h0, pc_out},      32'h03);
      tick();
    end
    chk("bp.pops_held", n_pop1, 2);

    q1.push_back('{16'h1000, 6'd4,  16'h0000, 8'h40});
    q1.push_back('{16'hFC00, 6'd63, 16'h0000, 8'h41});
    instr_ready = 1'b1;
    tick(); tick();                               // REQ_I(4), CAP_I
    chk("br.imm_rd_addr", {24'h0, mem_addr}, 32'h5);
    tick();                                       // CAP_M
    branch_en = 1'b1; branch_target = 8'h40;
    tick();
    branch_en = 1'b0;
    chk("br.valid",    {31'h0, instr_valid}, 32'h0);
    chk("br.mem_rd",   {31'h0, mem_rd},      32'h1);
    chk("br.mem_addr", {24'h0, mem_addr},    32'h40);

    for (int i = 0; i < 30 && !halted; i++) tick();
    chk("halt.reached", {31'h0, halted}, 32'h1);
    for (int i = 0; i < 12; i++) begin
      chk("halt.mem_rd", {31'h0, mem_rd},      32'h0);
      chk("halt.valid",  {31'h0, instr_valid}, 32'h0);
      chk("halt.held",   {31'h0, halted},      32'h1);
      tick();
    end

    q1.push_back('{16'h2600, 6'd9, 16'h5555, 8'h10});
    branch_en = 1'b1; branch_target = 8'h10;
    tick();
    branch_en = 1'b0;
    chk("resume.halted",   {31'h0, halted},   32'h0);
    chk("resume.mem_rd",   {31'h0, mem_rd},   32'h1);
    chk("resume.mem_addr", {24'h0, mem_addr}, 32'h10);
    for (int i = 0; i < 40 && n_pop1 < 6; i++) tick();
    instr_ready = 1'b0;
    chk("dut.pop_count", n_pop1, 6);

    q2.push_back('{16'h0600, 6'd1,  16'h0100, 8'hFF});
    q2.push_back('{16'h4A00, 6'd18, 16'h1234, 8'h01});
    q2.push_back('{16'h0800, 6'd2,  16'h0000, 8'h03});
    rst2 = 1'b1;
    tick();
    chk("wrap.first_addr", {24'h0, mem_addr2}, 32'hFF);
    tick();
    chk("wrap.imm_rd",   {31'h0, mem_rd2},   32'h1);
    chk("wrap.imm_addr", {24'h0, mem_addr2}, 32'h00);
    for (int i = 0; i < 60 && n_pop2 < 3; i++) tick();
    instr_ready2 = 1'b0;
    repeat (6) tick();
    chk("wrap.pop_count", n_pop2, 3);
    chk("dut.queue_empty",  q1.size(), 0);
    chk("wrap.queue_empty", q2.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
